// File: rtl/nebula_out_sched.sv
// Output-port scheduler: round-robin arbitration over input-VC requesters,
// gated by per-VC downstream credits, with optional wormhole locking per packet.
module nebula_out_sched #(
  parameter int NREQ    = 20,
  parameter int VCS     = 4,
  parameter int CREDITS = 8,
  parameter int LOCK_EN = 1,
  localparam int VCW = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int CW  = $clog2(CREDITS + 1),
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*VCW-1:0] req_vc,
  input  logic [NREQ-1:0]     req_tail,
  input  logic                tx_ready,
  input  logic                credit_valid,
  input  logic [VCW-1:0]      credit_vc,
  output logic [NREQ-1:0]     gnt,
  output logic                gnt_valid,
  output logic [IW-1:0]       gnt_idx,
  output logic [VCS*CW-1:0]   credit_cnt,
  output logic                locked,
  output logic                credit_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_held_idx;
  logic          r_held_vld;
  logic [CW-1:0] r_credit [VCS];
  logic          r_credit_err;

  logic [NREQ-1:0] w_elig;
  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic [IW:0]     w_scan;
  logic [VCW-1:0]  w_gnt_vc;
  logic            w_gnt_tail;
  logic            w_fire;
  logic [VCS-1:0]  w_dec;
  logic [VCS-1:0]  w_inc;

  function automatic logic vc_in_range(input logic [VCW-1:0] vc);
    return (32'(vc) < VCS);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A requester is eligible only if its target VC exists and has a credit now.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && vc_in_range(req_vc[i*VCW +: VCW]))
        w_elig[i] = (r_credit[req_vc[i*VCW +: VCW]] != '0);
    end
  end

  // Priority: locked owner, then a stalled (held) grant, then round-robin scan.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    if (r_state == ST_LOCKED) begin
      if (w_elig[r_owner]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = r_owner;
      end
    end else if (r_held_vld && w_elig[r_held_idx]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_held_idx;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        w_scan = {1'b0, r_rr_ptr} + (IW+1)'(k);
        if (w_scan >= (IW+1)'(NREQ))
          w_scan = w_scan - (IW+1)'(NREQ);
        if (!w_gnt_vld && w_elig[w_scan[IW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_scan[IW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt        = '0;
    w_gnt_vc   = '0;
    w_gnt_tail = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IW'(i)) begin
        gnt[i]     = w_gnt_vld;
        w_gnt_vc   = req_vc[i*VCW +: VCW];
        w_gnt_tail = req_tail[i];
      end
    end
  end

  assign w_fire    = w_gnt_vld & tx_ready;
  assign gnt_valid = w_gnt_vld;
  assign gnt_idx   = w_gnt_idx;
  assign locked    = (r_state == ST_LOCKED);
  assign credit_err = r_credit_err;

  // Arbitration state: the pointer only advances on a fire in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_held_vld <= 1'b0;
      r_held_idx <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_fire) begin
        r_held_vld <= 1'b0;
        r_rr_ptr   <= next_idx(w_gnt_idx);
        if (!w_gnt_tail && (LOCK_EN != 0)) begin
          r_state <= ST_LOCKED;
          r_owner <= w_gnt_idx;
        end
      end else if (w_gnt_vld) begin
        r_held_vld <= 1'b1;
        r_held_idx <= w_gnt_idx;
      end else begin
        r_held_vld <= 1'b0;
      end
    end else if (w_fire && w_gnt_tail) begin
      r_state <= ST_IDLE;
    end
  end

  always_comb begin
    w_dec = '0;
    w_inc = '0;
    for (int v = 0; v < VCS; v++) begin
      w_dec[v] = w_fire && (w_gnt_vc == VCW'(v));
      w_inc[v] = credit_valid && (credit_vc == VCW'(v));
    end
  end

  // Simultaneous send and return on one VC cancel; a return into a full VC is an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VCS; v++)
        r_credit[v] <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      if (credit_valid && !vc_in_range(credit_vc))
        r_credit_err <= 1'b1;
      for (int v = 0; v < VCS; v++) begin
        if (w_inc[v] && !w_dec[v]) begin
          if (r_credit[v] == CW'(CREDITS))
            r_credit_err <= 1'b1;
          else
            r_credit[v] <= r_credit[v] + 1'b1;
        end else if (w_dec[v] && !w_inc[v]) begin
          r_credit[v] <= r_credit[v] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    credit_cnt = '0;
    for (int v = 0; v < VCS; v++)
      credit_cnt[v*CW +: CW] = r_credit[v];
  end

endmodule

// File: tb/tb_nebula_out_sched.sv
// Bench for nebula_out_sched: directed vector tables, hand-written corner
// sequences and a randomized run against a behavioural scheduler model.
module tb_nebula_out_sched;

  localparam int NREQ    = 20;
  localparam int VCS     = 4;
  localparam int CREDITS = 8;
  localparam int LOCK_EN = 1;
  localparam int VCW     = 2;
  localparam int CW      = 4;
  localparam int IW      = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*VCW-1:0] req_vc = '0;
  logic [NREQ-1:0]     req_tail = '0;
  logic                tx_ready = 1'b0;
  logic                credit_valid = 1'b0;
  logic [VCW-1:0]      credit_vc = '0;
  logic [NREQ-1:0]     gnt;
  logic                gnt_valid;
  logic [IW-1:0]       gnt_idx;
  logic [VCS*CW-1:0]   credit_cnt;
  logic                locked;
  logic                credit_err;

  nebula_out_sched #(
    .NREQ(NREQ), .VCS(VCS), .CREDITS(CREDITS), .LOCK_EN(LOCK_EN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vc(req_vc),
    .req_tail(req_tail), .tx_ready(tx_ready), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
    .credit_cnt(credit_cnt), .locked(locked), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_locked, m_held, m_err;
  int m_owner, m_ptr, m_held_idx;
  int m_cred [VCS];
  bit e_vld;
  int e_idx;

  function automatic int vc_of(int i);
    return int'(req_vc[i*VCW +: VCW]);
  endfunction

  function automatic bit bit_of(logic [NREQ-1:0] vec, int i);
    return vec[IW'(i)];
  endfunction

  function automatic bit m_elig(int i);
    int vc;
    vc = vc_of(i);
    return bit_of(req_valid, i) && (vc < VCS) && (m_cred[vc] != 0);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_held = 0; m_err = 0;
    m_owner = 0; m_ptr = 0; m_held_idx = 0;
    for (int v = 0; v < VCS; v++) m_cred[v] = CREDITS;
  endtask

  // Pick the eligible requester closest (cyclically) at or after the pointer.
  task automatic model_eval();
    int best, d;
    e_vld = 0; e_idx = 0; best = NREQ;
    if (m_locked) begin
      if (m_elig(m_owner)) begin e_vld = 1; e_idx = m_owner; end
    end else if (m_held && m_elig(m_held_idx)) begin
      e_vld = 1; e_idx = m_held_idx;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_elig(i)) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (d < best) begin best = d; e_vld = 1; e_idx = i; end
        end
      end
    end
  endtask

  task automatic model_update();
    bit fire;
    int gvc, d, nc;
    fire = e_vld && tx_ready;
    gvc  = e_vld ? vc_of(e_idx) : -1;
    for (int v = 0; v < VCS; v++) begin
      d = 0;
      if (credit_valid && int'(credit_vc) == v) d = d + 1;
      if (fire && gvc == v) d = d - 1;
      nc = m_cred[v] + d;
      if (nc > CREDITS) begin nc = CREDITS; m_err = 1; end
      m_cred[v] = nc;
    end
    if (credit_valid && int'(credit_vc) >= VCS) m_err = 1;
    if (!m_locked) begin
      if (fire) begin
        m_held = 0;
        m_ptr = (e_idx + 1) % NREQ;
        if (!bit_of(req_tail, e_idx) && LOCK_EN != 0) begin m_locked = 1; m_owner = e_idx; end
      end else if (e_vld) begin
        m_held = 1; m_held_idx = e_idx;
      end else begin
        m_held = 0;
      end
    end else if (fire && bit_of(req_tail, e_idx)) begin
      m_locked = 0;
    end
  endtask

  // ---------------- cycle helpers ----------------
  task automatic sample();
    logic [NREQ-1:0]   eg;
    logic [VCS*CW-1:0] ec;
    @(negedge clk);
    model_eval();
    eg = e_vld ? (NREQ'(1) << e_idx) : '0;
    for (int v = 0; v < VCS; v++) ec[v*CW +: CW] = CW'(m_cred[v]);
    chk("model gnt_valid", gnt_valid, e_vld);
    chk("model gnt_idx", gnt_idx, e_vld ? e_idx : 0);
    chk("model gnt", gnt, eg);
    chk("model locked", locked, m_locked);
    chk("model credit_cnt", credit_cnt, ec);
    chk("model credit_err", credit_err, m_err);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_vc = '0; req_tail = '0;
    tx_ready = 1'b0; credit_valid = 1'b0; credit_vc = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] t;
    logic            rdy;
    logic            eg;
    int              ei;
    logic            el;
  } vec_t;

  vec_t  tbl[$];
  string sect;

  task automatic add_row(input logic [NREQ-1:0] v, input logic [NREQ-1:0] t,
                         input logic rdy, input logic eg, input int ei, input logic el);
    vec_t r;
    r.v = v; r.t = t; r.rdy = rdy; r.eg = eg; r.ei = ei; r.el = el;
    tbl.push_back(r);
  endtask

  task automatic run_rows();
    foreach (tbl[r]) begin
      req_valid = tbl[r].v;
      req_tail  = tbl[r].t;
      tx_ready  = tbl[r].rdy;
      sample();
      chk($sformatf("%s row%0d gnt_valid", sect, r), gnt_valid, tbl[r].eg);
      if (tbl[r].eg) chk($sformatf("%s row%0d gnt_idx", sect, r), gnt_idx, tbl[r].ei);
      chk($sformatf("%s row%0d locked", sect, r), locked, tbl[r].el);
      advance();
    end
    tbl.delete();
  endtask

  int nf;

  initial begin
    model_reset();
    do_reset();

    // Reset values
    sample();
    chk("reset gnt_valid", gnt_valid, 0);
    chk("reset gnt", gnt, 0);
    chk("reset gnt_idx", gnt_idx, 0);
    chk("reset locked", locked, 0);
    chk("reset credit_cnt", credit_cnt, 16'h8888);
    chk("reset credit_err", credit_err, 0);
    advance();

    // Fairness among 3, 7, 15 with single-flit packets
    sect = "fair";
    req_vc = '0;
    for (int k = 0; k < 2; k++) begin
      add_row(20'h08088, '1, 1'b1, 1'b1, 3, 1'b0);
      add_row(20'h08088, '1, 1'b1, 1'b1, 7, 1'b0);
      add_row(20'h08088, '1, 1'b1, 1'b1, 15, 1'b0);
    end
    run_rows();

    // Wormhole lock: 4-flit packet from 2 with a gap, 5 waiting on VC1
    do_reset();
    sect = "worm";
    req_vc = 40'h400;
    add_row(20'h00024, 20'h00020, 1'b1, 1'b1, 2, 1'b0);
    add_row(20'h00024, 20'h00020, 1'b1, 1'b1, 2, 1'b1);
    add_row(20'h00020, 20'h00020, 1'b1, 1'b0, 0, 1'b1);
    add_row(20'h00024, 20'h00020, 1'b1, 1'b1, 2, 1'b1);
    add_row(20'h00024, 20'h00024, 1'b1, 1'b1, 2, 1'b1);
    add_row(20'h00020, 20'h00020, 1'b1, 1'b1, 5, 1'b0);
    run_rows();

    // Backpressure hold: pointer at 5, grant 9 held while 6 arrives
    do_reset();
    sect = "hold";
    req_vc = '0;
    add_row(20'h00010, '1, 1'b1, 1'b1, 4, 1'b0);
    add_row(20'h00210, '1, 1'b0, 1'b1, 9, 1'b0);
    add_row(20'h00250, '1, 1'b0, 1'b1, 9, 1'b0);
    add_row(20'h00250, '1, 1'b0, 1'b1, 9, 1'b0);
    add_row(20'h00250, '1, 1'b1, 1'b1, 9, 1'b0);
    add_row(20'h00250, '1, 1'b1, 1'b1, 4, 1'b0);
    add_row(20'h00250, '1, 1'b1, 1'b1, 6, 1'b0);
    run_rows();

    // Credit exhaustion on VC1, then one returned credit
    do_reset();
    req_vc = 40'h4; req_valid = 20'h2; req_tail = '1; tx_ready = 1'b1;
    nf = 0;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (gnt_valid && tx_ready) nf++;
      chk($sformatf("exhaust c%0d gnt_valid", c), gnt_valid, (c < 8));
      advance();
    end
    chk("exhaust fire count", nf, 8);
    chk("exhaust cnt vc1", credit_cnt[1*CW +: CW], 0);
    credit_valid = 1'b1; credit_vc = 2'd1;
    sample();
    chk("credit cycle t gnt_valid", gnt_valid, 0);
    advance();
    credit_valid = 1'b0;
    sample();
    chk("credit t+1 gnt_valid", gnt_valid, 1);
    chk("credit t+1 gnt_idx", gnt_idx, 1);
    advance();
    sample();
    chk("credit spent gnt_valid", gnt_valid, 0);
    advance();

    // Simultaneous fire and credit on VC2; overflow on VC3
    do_reset();
    req_vc = 40'd2; req_valid = 20'h1; req_tail = '1; tx_ready = 1'b1;
    repeat (5) begin sample(); advance(); end
    chk("pre cnt vc2", credit_cnt[2*CW +: CW], 3);
    credit_valid = 1'b1; credit_vc = 2'd2;
    sample();
    chk("fire+credit grant", gnt_valid, 1);
    advance();
    credit_valid = 1'b0; req_valid = '0;
    sample();
    chk("fire+credit cnt vc2", credit_cnt[2*CW +: CW], 3);
    advance();
    credit_valid = 1'b1; credit_vc = 2'd3;
    sample();
    chk("pre-overflow err", credit_err, 0);
    advance();
    credit_valid = 1'b0;
    sample();
    chk("overflow cnt vc3", credit_cnt[3*CW +: CW], 8);
    chk("overflow err", credit_err, 1);
    advance();

    // Reset in the middle of a locked packet
    do_reset();
    req_vc = '0; req_tail = '0; req_valid = 20'h1; tx_ready = 1'b1;
    credit_valid = 1'b1; credit_vc = 2'd3;
    sample(); advance();
    credit_valid = 1'b0;
    repeat (5) begin sample(); advance(); end
    sample();
    chk("midlock locked", locked, 1);
    chk("midlock cnt vc0", credit_cnt[0 +: CW], 2);
    chk("midlock err", credit_err, 1);
    rst_n = 1'b0;
    #1;
    chk("after reset locked", locked, 0);
    chk("after reset cnt vc0", credit_cnt[0 +: CW], 8);
    chk("after reset err", credit_err, 0);
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 20'h3; req_tail = '1; tx_ready = 1'b1;
    sample();
    chk("after reset rr_ptr", gnt_idx, 0);
    advance();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int v;
      req_valid = NREQ'($urandom & $urandom);
      req_vc    = {8'($urandom), 32'($urandom)};
      req_tail  = NREQ'($urandom);
      tx_ready  = ($urandom_range(0, 3) != 0);
      credit_valid = 1'b0;
      credit_vc = '0;
      if ($urandom_range(0, 3) != 0) begin
        v = $urandom_range(0, VCS - 1);
        if (m_cred[v] < CREDITS || $urandom_range(0, 99) == 0) begin
          credit_valid = 1'b1;
          credit_vc = VCW'(v);
        end
      end
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nebula_out_sched.md
# nebula_out_sched

Credit-aware, wormhole-locking output-port scheduler for one router output link. It arbitrates among NREQ input-VC requesters (PORTS*VCS of the router) with round-robin fairness. A flit is granted only when the downstream VC it targets has a free credit. Once a packet's head flit is sent, the grant is locked to that requester until its tail flit is sent. One instance sits in front of each output port and drives that port's tx_valid and the input FIFO pops.

## Interface
- NREQ, default 20: number of requesters (input port × VC).
- VCS, default 4: downstream virtual channels.
- CREDITS, default 8: downstream FIFO depth per VC, i.e. the initial credit count.
- LOCK_EN, default 1: 1 enables wormhole locking; 0 re-arbitrates every flit.
- Derived widths: VCW = max(1,$clog2(VCS)), CW = $clog2(CREDITS+1), IW = max(1,$clog2(NREQ)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has a flit at its FIFO head.
- req_vc  in  NREQ*VCW  downstream VC targeted by requester i, at bits [i*VCW +: VCW].
- req_tail  in  NREQ  requester i's head flit is the last flit of its packet.
- tx_ready  in  1  downstream link accepts a flit this cycle.
- credit_valid  in  1  one credit returned this cycle.
- credit_vc  in  VCW  VC of the returned credit.
- gnt  out  NREQ  one-hot grant; pop[i] = gnt[i] & tx_ready.
- gnt_valid  out  1  a grant exists; drives tx_valid.
- gnt_idx  out  IW  index of the granted requester; 0 when gnt_valid=0.
- credit_cnt  out  VCS*CW  registered credit count per VC.
- locked  out  1  state is LOCKED.
- credit_err  out  1  sticky error flag; cleared only by reset.

## Operation
- Fire = gnt_valid & tx_ready.
- Eligible[i] = req_valid[i] & (req_vc[i] < VCS) & (credit_cnt[req_vc[i]] != 0).

**Credit counters**, one per VC, registered:
- A fire on VC v decrements credit_cnt[v].
- credit_valid on VC v increments credit_cnt[v].
- Both on the same VC in the same cycle: the count is unchanged.
- An increment at CREDITS with no decrement saturates at CREDITS and sets credit_err.
- credit_vc >= VCS is ignored and sets credit_err.

**State machine**:
- IDLE:
  - If held_vld=1 and the held requester is still eligible, grant it.
  - Otherwise grant the first eligible index searching from rr_ptr upward, modulo NREQ.
  - gnt_valid=1 without tx_ready: latch held_idx and set held_vld.
  - Fire: clear held_vld and set rr_ptr to winner+1 mod NREQ. If req_tail[winner]=0 and LOCK_EN=1, go to LOCKED with owner=winner.
- LOCKED:
  - Only the owner may be granted, and only while eligible. All other requesters are masked.
  - If the owner drops req_valid or lacks credit, gnt_valid=0 and the state stays LOCKED (bubble).
  - Fire with req_tail[owner]=1: go to IDLE.
  - rr_ptr does not change in LOCKED.
- A held grant whose requester is no longer eligible is released: clear held_vld and re-arbitrate in the same cycle.
- gnt, gnt_valid and gnt_idx are combinational from the registered state (state, owner, rr_ptr, held, credit_cnt) and the current inputs.

## Timing
- Grant latency is 0 cycles: req_valid at cycle t gives gnt at cycle t if the requester is eligible.
- A credit returned at cycle t makes its VC eligible at t+1.
- A fire at t decrements the count seen at t+1.
- Back-to-back fires are supported: one flit per cycle while credits last.
- A granted index is stable until fire, unless its requester stops being eligible.
- Reset values: state=IDLE, rr_ptr=0, held_vld=0, owner=0, every credit_cnt=CREDITS, gnt=0, gnt_valid=0 (given no requests), gnt_idx=0, locked=0, credit_err=0.
- Reset mid-packet: the lock is dropped and credits are restored to CREDITS.
- No more than one grant is ever asserted. gnt=0 whenever gnt_valid=0.

## Test plan
- Fairness: NREQ=20, requesters 3, 7 and 15 each send single-flit packets, tx_ready=1 → grants 3, 7, 15, 3, ... on consecutive cycles, and rr_ptr=4 after the first fire.
- Wormhole lock: requester 2 sends a 4-flit packet and requester 5 requests continuously → 4 grants to 2, then 5. locked=1 from the first fire until the tail fire. A 1-cycle gap on req_valid[2] mid-packet produces gnt_valid=0 with locked=1.
- Credit exhaustion: CREDITS=8, one requester on VC1, no credits returned → exactly 8 fires, then gnt_valid=0. A credit on VC1 at cycle t allows a grant at t+1.
- Backpressure hold: tx_ready=0 for 3 cycles with requesters 4 and 9 valid and rr_ptr=5 → gnt stays on 9 across the stall even after requester 6 becomes valid.
- Simultaneous fire and credit on the same VC with credit_cnt=3 → count stays 3. A credit at count 8 with no fire → count stays 8 and credit_err=1.
- Reset mid-LOCKED with credit_cnt[0]=2 → after reset locked=0, credit_cnt[0]=8, rr_ptr=0, credit_err=0.
